// File: rtl/string_tx_pkg.sv
// string_tx_pkg: shared types and message contents for the string_tx transmitter.
// Build option: define STRING_TX_CRLF_EN to append CR LF to the message.
package string_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_GAP_WAIT = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    localparam logic [7:0] CH_I  = 8'd73;
    localparam logic [7:0] CH_N  = 8'd110;
    localparam logic [7:0] CH_C  = 8'd99;
    localparam logic [7:0] CH_O  = 8'd111;
    localparam logic [7:0] CH_R  = 8'd114;
    localparam logic [7:0] CH_CR = 8'd13;
    localparam logic [7:0] CH_LF = 8'd10;

`ifdef STRING_TX_CRLF_EN
    localparam int unsigned MSG_LEN = 8;
`else
    localparam int unsigned MSG_LEN = 6;
`endif

    localparam logic [7:0] LAST_INDEX = 8'(MSG_LEN - 1);

    // Index -> message byte; out-of-range indices read as zero.
    function automatic logic [7:0] msg_byte(input logic [7:0] index);
        logic [7:0] b;
        b = '0;
        case (index)
            8'd0:    b = CH_I;
            8'd1:    b = CH_N;
            8'd2:    b = CH_C;
            8'd3:    b = CH_O;
            8'd4:    b = CH_R;
            8'd5:    b = CH_R;
`ifdef STRING_TX_CRLF_EN
            8'd6:    b = CH_CR;
            8'd7:    b = CH_LF;
`endif
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/string_tx_rom.sv
// string_tx_rom: combinational message byte lookup.
// Contents follow STRING_TX_CRLF_EN through string_tx_pkg.
module string_tx_rom (
    input  logic [7:0] index,
    output logic [7:0] data
);
    import string_tx_pkg::*;

    // Pure table lookup, no state.
    always_comb begin
        data = msg_byte(index);
    end

endmodule

// File: rtl/string_tx.sv
// string_tx: sends a fixed ASCII message over a valid/ready byte interface.
// Build option: STRING_TX_CRLF_EN appends CR LF to the message (see string_tx_pkg).
// One request may be queued while a message is in flight; extras are dropped.
module string_tx #(
    parameter int unsigned GAP                = 0,
    parameter int unsigned ABORT_ON_RESET_REQ = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);
    import string_tx_pkg::*;

    localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    // Reject configurations this implementation does not support.
    generate
        if (ABORT_ON_RESET_REQ != 0 || GAP > 255) begin : g_bad_config
            $error("string_tx: unsupported parameters (ABORT_ON_RESET_REQ must be 0, GAP <= 255)");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [7:0] index_q, index_d;
    logic [7:0] gap_q,   gap_d;
    logic       pending_q, pending_d;
    logic [7:0] rom_data;

    string_tx_rom u_rom (
        .index (index_q),
        .data  (rom_data)
    );

    // State register, message index, gap counter and queued request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            gap_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        gap_d     = gap_q;
        pending_d = pending_q;

        tx_valid  = 1'b0;
        tx_data   = '0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (send) begin
                    state_d = ST_SEND;
                    index_d = '0;
                end
            end

            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = rom_data;
                if (send) begin
                    pending_d = 1'b1;
                end
                if (tx_ready) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_FINISH;
                    end else if (GAP == 0) begin
                        index_d = index_q + 8'd1;
                    end else begin
                        state_d = ST_GAP_WAIT;
                        gap_d   = GAP_LOAD;
                    end
                end
            end

            ST_GAP_WAIT: begin
                if (send) begin
                    pending_d = 1'b1;
                end
                if (gap_q == '0) begin
                    index_d = index_q + 8'd1;
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            ST_FINISH: begin
                done    = 1'b1;
                index_d = '0;
                gap_d   = '0;
                // A request arriving in this very cycle is honoured like a queued one.
                if (pending_q || send) begin
                    pending_d = 1'b0;
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_string_tx.sv
// tb_string_tx: scoreboard bench for string_tx, run on a GAP=0 and a GAP=3 instance.
// The reference model keeps the outstanding work as a queue of cycle slots
// (byte offers, idle gap cycles, finish) plus a one-deep request flag.
module tb_string_tx;

`ifdef STRING_TX_CRLF_EN
    localparam int MSG_N = 8;
`else
    localparam int MSG_N = 6;
`endif
    localparam int MAX_CYCLES = 20000;
    localparam int SLOT_IDLE  = -1;
    localparam int SLOT_FIN   = -2;
    localparam int DONE_MARK  = 256;

    typedef struct {
        bit busy;
        bit valid;
        int data;
        bit done;
    } cyc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    bit lane_done [2];

    function automatic int msg_at(input int i);
        int m [8] = '{73, 110, 99, 111, 114, 114, 13, 10};
        return m[i];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned LG = (g == 0) ? 0 : 3;

        logic       rst_n;
        logic       send;
        logic       tx_ready;
        logic       tx_valid;
        logic       busy;
        logic       done;
        logic [7:0] tx_data;

        string_tx #(.GAP(LG), .ABORT_ON_RESET_REQ(0)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .send     (send),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .busy     (busy),
            .done     (done)
        );

        cyc_t cyc_q  [$];
        int   xfer_q [$];
        int   slots  [$];
        bit   pend;
        int   last_popped;

        task automatic add_message();
            for (int i = 0; i < MSG_N; i++) begin
                slots.push_back(msg_at(i));
                if (i < MSG_N - 1) begin
                    for (int k = 0; k < int'(LG); k++) slots.push_back(SLOT_IDLE);
                end
            end
            slots.push_back(SLOT_FIN);
        endtask

        task automatic drive_and_expect(input bit s, input bit r);
            cyc_t c;
            int   head;
            @(negedge clk);
            send     = s;
            tx_ready = r;
            head     = (slots.size() != 0) ? slots[0] : -3;
            c.busy   = (slots.size() != 0);
            c.valid  = (head >= 0);
            c.data   = (head >= 0) ? head : 0;
            c.done   = (head == SLOT_FIN);
            cyc_q.push_back(c);
            if (head >= 0 && r) xfer_q.push_back(head);
            if (head == SLOT_FIN) xfer_q.push_back(DONE_MARK);
        endtask

        task automatic model_step(input bit s, input bit r);
            int head;
            last_popped = -3;
            if (slots.size() == 0) begin
                if (s) add_message();
            end else begin
                head = slots[0];
                if (head == SLOT_FIN) begin
                    void'(slots.pop_front());
                    if (pend || s) begin
                        pend = 1'b0;
                        add_message();
                    end
                end else begin
                    if (s) pend = 1'b1;
                    if (head == SLOT_IDLE || r) begin
                        last_popped = head;
                        void'(slots.pop_front());
                    end
                end
            end
        endtask

        task automatic cycle(input bit s, input bit r);
            drive_and_expect(s, r);
            model_step(s, r);
        endtask

        task automatic drain();
            for (int i = 0; i < 600 && slots.size() != 0; i++) cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b1);
        endtask

        // Monitor: per-cycle outputs and the ordered stream of transfers / done pulses.
        initial begin
            cyc_t c;
            int   e;
            forever begin
                @(negedge clk);
                #1;
                if (cyc_q.size() != 0) begin
                    c = cyc_q.pop_front();
                    check($sformatf("lane%0d busy", g),     32'(busy),     32'(c.busy));
                    check($sformatf("lane%0d tx_valid", g), 32'(tx_valid), 32'(c.valid));
                    check($sformatf("lane%0d tx_data", g),  32'(tx_data),  32'(c.data));
                    check($sformatf("lane%0d done", g),     32'(done),     32'(c.done));
                end
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    if (xfer_q.size() == 0) begin
                        check($sformatf("lane%0d unexpected transfer", g), 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = xfer_q.pop_front();
                        check($sformatf("lane%0d transfer byte", g), 32'(tx_data), 32'(e));
                    end
                end
                if (done === 1'b1) begin
                    if (xfer_q.size() == 0) begin
                        check($sformatf("lane%0d unexpected done", g), 32'(done), 32'd0);
                    end else begin
                        e = xfer_q.pop_front();
                        check($sformatf("lane%0d done order", g), 32'(e), 32'(DONE_MARK));
                    end
                end
            end
        end

        // Stimulus: directed scenarios followed by a random phase and a mid-message reset.
        initial begin
            int  stalls;
            bit  r;
            rst_n    = 1'b0;
            send     = 1'b0;
            tx_ready = 1'b0;
            pend     = 1'b0;
            #2;
            check($sformatf("lane%0d reset tx_valid", g), 32'(tx_valid), 32'd0);
            check($sformatf("lane%0d reset tx_data", g),  32'(tx_data),  32'd0);
            check($sformatf("lane%0d reset busy", g),     32'(busy),     32'd0);
            check($sformatf("lane%0d reset done", g),     32'(done),     32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3) cycle(1'b0, 1'b1);

            // Single message, receiver always ready.
            cycle(1'b1, 1'b1);
            drain();

            // Receiver stalls five cycles on the third byte.
            cycle(1'b1, 1'b1);
            stalls = 0;
            for (int i = 0; i < 600 && slots.size() != 0; i++) begin
                r = 1'b1;
                if (slots[0] == msg_at(2) && stalls < 5) begin
                    r = 1'b0;
                    stalls++;
                end
                cycle(1'b0, r);
            end
            cycle(1'b0, 1'b1);

            // Three requests during a message: exactly one is queued.
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b1);
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b1);
            cycle(1'b1, 1'b1);
            cycle(1'b1, 1'b1);
            drain();

            // Random requests and receiver back-pressure.
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            end
            drain();

            // Reset right after the fourth byte has transferred.
            cycle(1'b1, 1'b1);
            for (int i = 0; i < 600; i++) begin
                cycle(1'b0, 1'b1);
                if (last_popped == msg_at(3)) break;
            end
            drive_and_expect(1'b0, 1'b0);
            #3;
            rst_n = 1'b0;
            #1;
            check($sformatf("lane%0d async reset tx_valid", g), 32'(tx_valid), 32'd0);
            check($sformatf("lane%0d async reset tx_data", g),  32'(tx_data),  32'd0);
            check($sformatf("lane%0d async reset busy", g),     32'(busy),     32'd0);
            check($sformatf("lane%0d async reset done", g),     32'(done),     32'd0);
            slots.delete();
            xfer_q.delete();
            pend = 1'b0;
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b1);
            rst_n = 1'b1;
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b1);
            cycle(1'b1, 1'b1);
            drain();

            #2;
            check($sformatf("lane%0d leftover expected events", g), 32'(xfer_q.size()), 32'd0);
            lane_done[g] = 1'b1;
        end
    end

    // Bounded run: summary once both lanes finish or the cycle budget expires.
    initial begin
        for (int i = 0; i < MAX_CYCLES; i++) begin
            @(posedge clk);
            if (lane_done[0] && lane_done[1]) break;
        end
        if (!(lane_done[0] && lane_done[1])) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: lanes finished %0d/%0d, required 1/1", lane_done[0], lane_done[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/string_tx.md
STRING_TX -- requirements
Module: string_tx

Interface
REQ-001 Parameter GAP, default 0: idle cycles inserted between consecutive bytes of one message (0..255).
REQ-002 Parameter ABORT_ON_RESET_REQ, default 0: reserved, SHALL be 0; nonzero values are unsupported.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous and active-low.
REQ-005 send  in  1  request pulse; starts transmission of the fixed message.
REQ-006 tx_data  out  8  byte offered to the UART transmitter.
REQ-007 tx_valid  out  1  tx_data is valid.
REQ-008 tx_ready  in  1  UART transmitter accepts a byte; transfer occurs when tx_valid && tx_ready.
REQ-009 busy  out  1  high from request acceptance until after the last byte transfers.
REQ-010 done  out  1  one-cycle pulse after the last byte transfers.

Function
REQ-011 Message bytes SHALL be 73, 110, 99, 111, 114, 114 ("Incorr"), sent in that order; MSG_LEN = 6.
- Optional CR LF extension: see REQ-026.
REQ-012 FSM states: IDLE, SEND, GAP_WAIT, FINISH.
REQ-013 IDLE: send=1 -> SEND next cycle, index=0, busy=1.
- tx_valid SHALL be 1 in that same next cycle.
- Latency: send sampled high -> tx_valid high = 1 cycle.
REQ-014 SEND: tx_valid=1, tx_data=msg[index].
- Both SHALL hold stable until tx_ready=1; no withdrawal.
REQ-015 On transfer in SEND, index < MSG_LEN-1:
- GAP=0: increment index and stay in SEND; the next byte is valid in the next cycle, so back-to-back transfer is possible.
- GAP>0: go to GAP_WAIT with the gap counter loaded to GAP-1.
REQ-016 GAP_WAIT: tx_valid=0; count down to 0, then increment index and go to SEND.
REQ-017 On transfer of the last byte: go to FINISH.
REQ-018 FINISH: done=1 for exactly one cycle, busy=1, tx_valid=0.
- Then go to IDLE, busy=0.
REQ-019 send while not IDLE: latch one pending request (one-deep).
- Further requests while a request is already pending SHALL be dropped.
REQ-020 FINISH with a request pending: clear the pending flag and go to SEND with index=0; busy stays high.
- send=1 in the FINISH cycle counts as pending.
REQ-021 tx_data SHALL read 0 whenever tx_valid=0.
REQ-022 Index and gap counter SHALL be 8-bit unsigned and SHALL never exceed MSG_LEN-1 or GAP-1 respectively.

Reset
REQ-023 rst_n low SHALL immediately force the following regardless of clk, including mid-message: state=IDLE, index=0, gap=0, pending=0, tx_valid=0, tx_data=0, busy=0, done=0.
REQ-024 Reset release SHALL generate no transfer.
- The first send sampled after release starts a full message from byte 0.

Configuration
REQ-025 Macro STRING_TX_CRLF_EN controls the CR LF extension.
REQ-026 Macro defined: message = 73, 110, 99, 111, 114, 114, 13, 10; MSG_LEN = 8.
- Macro undefined: the 6-byte message of REQ-011, MSG_LEN = 6.
- All other behaviour identical.

Structure
REQ-027 Package string_tx_pkg SHALL hold:
- state enum;
- message byte constants;
- MSG_LEN, selected by STRING_TX_CRLF_EN.
REQ-028 Sub-module string_tx_rom (combinational index -> byte lookup) SHALL be instantiated once.
- The FSM, pending flag and counters SHALL stay in string_tx.

Verification
REQ-029 GAP=0, tx_ready tied 1, one send pulse -> 6 consecutive transfers 73, 110, 99, 111, 114, 114 starting 1 cycle after send; done pulses 1 cycle after the last transfer.
REQ-030 GAP=3, tx_ready=1 -> exactly 3 cycles with tx_valid=0 between each transfer; total busy = 6 + 5*3 + 1 = 22 cycles.
REQ-031 tx_ready low for 5 cycles on byte 2 -> tx_valid=1 and tx_data=99 held all 5 cycles; no byte duplicated or skipped.
REQ-032 Three send pulses during message 1 -> exactly two messages sent back-to-back; busy stays high throughout; done pulses twice.
REQ-033 rst_n asserted after byte 3 transfers -> all outputs 0 asynchronously; a new send after release starts at 73.
REQ-034 STRING_TX_CRLF_EN defined -> 8 transfers ending 13, 10; done follows byte 10.
